// File: rtl/ibex_pmu_counter_bank.sv
// rtl/ibex_pmu_counter_bank.sv - PMU counter bank: event down-counters with register and wait-for-pulse access

package ibex_pkg;
    typedef enum logic [1:0] {
        PMC_IDLE = 2'd0,
        PMC_REQ  = 2'd1,
        PMC_WFP  = 2'd2
    } pmc_op_e;
endpackage

module ibex_pmu_counter_bank
    import ibex_pkg::*;
#(
    parameter int unsigned NumCounters = 8,
    parameter logic [31:0] BaseAddr    = 32'h0000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  pmc_op_e                counter_op_i,
    output logic                   counter_gnt_o,
    output logic                   counter_rvalid_o,
    output logic                   counter_err_o,
    input  logic [31:0]            counter_addr_i,
    input  logic [31:0]            counter_we_i,
    input  logic [31:0]            counter_wdata_i,
    output logic [31:0]            counter_rdata_o,
    input  logic [NumCounters-1:0] event_i,
    output logic [NumCounters-1:0] pending_o
);

    typedef enum logic [1:0] {
        StIdle,
        StResp,
        StWait
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            cnt_q [NumCounters];
    logic [31:0]            cnt_d [NumCounters];
    logic [NumCounters-1:0] en_q, en_d;
    logic [NumCounters-1:0] pend_q, pend_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic                   unused_we;
    logic [4:0]             word;
    logic                   in_window, aligned, sel_cnt, sel_en, sel_pend, addr_ok;
    logic                   accept, req_acc, wr;
    logic [31:0]            rd_val;
    logic                   pend_any, wfp_hit;
    logic [31:0]            low_idx;
    logic [NumCounters-1:0] low_mask, set_mask, clr_mask;

    assign unused_we = ^counter_we_i[31:1];

    // Address decode: the window is 128 bytes, so bits [6:2] pick the word.
    assign word      = counter_addr_i[6:2];
    assign in_window = counter_addr_i[31:7] == BaseAddr[31:7];
    assign aligned   = counter_addr_i[1:0] == 2'b00;
    assign sel_cnt   = !word[4] && (32'(word[3:0]) < NumCounters);
    assign sel_en    = word == 5'h10;
    assign sel_pend  = word == 5'h11;
    assign addr_ok   = in_window && aligned && (sel_cnt || sel_en || sel_pend);

    assign accept  = (state_q == StIdle) && (counter_op_i != PMC_IDLE);
    assign req_acc = accept && (counter_op_i == PMC_REQ);
    assign wr      = req_acc && addr_ok && counter_we_i[0];

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < int'(NumCounters); i++) begin
            if (sel_cnt && (word[3:0] == 4'(i))) begin
                rd_val = cnt_q[i];
            end
        end
        if (sel_en) begin
            rd_val = 32'(en_q);
        end
        if (sel_pend) begin
            rd_val = 32'(pend_q);
        end
    end

    always_comb begin
        low_idx  = '0;
        low_mask = '0;
        for (int i = int'(NumCounters) - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                low_idx     = 32'(i);
                low_mask    = '0;
                low_mask[i] = 1'b1;
            end
        end
    end

    assign pend_any = |pend_q;
    assign wfp_hit  = (state_q == StWait) && pend_any;

    // A register write to a counter overrides that cycle's decrement and its expiry.
    always_comb begin
        set_mask = '0;
        for (int i = 0; i < int'(NumCounters); i++) begin
            cnt_d[i] = cnt_q[i];
            if (wr && sel_cnt && (word[3:0] == 4'(i))) begin
                cnt_d[i] = counter_wdata_i;
            end else if (en_q[i] && event_i[i] && (cnt_q[i] != 32'd0)) begin
                cnt_d[i]    = cnt_q[i] - 32'd1;
                set_mask[i] = cnt_q[i] == 32'd1;
            end
        end
    end

    always_comb begin
        clr_mask = '0;
        if (wr && sel_pend) begin
            clr_mask = counter_wdata_i[NumCounters-1:0];
        end
        if (wfp_hit) begin
            clr_mask = clr_mask | low_mask;
        end
        pend_d = (pend_q & ~clr_mask) | set_mask;
        en_d   = (wr && sel_en) ? counter_wdata_i[NumCounters-1:0] : en_q;
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (req_acc) begin
            rdata_d = addr_ok ? rd_val : 32'd0;
            err_d   = !addr_ok;
        end else if (wfp_hit) begin
            rdata_d = low_idx;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            for (int i = 0; i < int'(NumCounters); i++) begin
                cnt_q[i] <= '0;
            end
            en_q    <= '0;
            pend_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (counter_op_i == PMC_REQ) begin
                    state_d = StResp;
                end else if (counter_op_i == PMC_WFP) begin
                    state_d = StWait;
                end
            end
            StResp: state_d = StIdle;
            StWait: begin
                if (pend_any) begin
                    state_d = StResp;
                end else if (counter_op_i == PMC_IDLE) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        counter_gnt_o    = state_q == StIdle;
        counter_rvalid_o = state_q == StResp;
        counter_err_o    = (state_q == StResp) && err_q;
        counter_rdata_o  = rdata_q;
        pending_o        = pend_q;
    end

endmodule

// File: tb/tb_ibex_pmu_counter_bank.sv
// tb/tb_ibex_pmu_counter_bank.sv - directed and randomized checks of the PMU counter bank against a reference model

module tb_ibex_pmu_counter_bank;
    import ibex_pkg::*;

    localparam int          N    = 8;
    localparam logic [31:0] BASE = 32'h4000_0080;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    pmc_op_e       counter_op_i;
    logic          counter_gnt_o, counter_rvalid_o, counter_err_o;
    logic [31:0]   counter_addr_i, counter_we_i, counter_wdata_i, counter_rdata_o;
    logic [N-1:0]  event_i, pending_o;

    ibex_pmu_counter_bank #(.NumCounters(N), .BaseAddr(BASE)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .counter_op_i     (counter_op_i),
        .counter_gnt_o    (counter_gnt_o),
        .counter_rvalid_o (counter_rvalid_o),
        .counter_err_o    (counter_err_o),
        .counter_addr_i   (counter_addr_i),
        .counter_we_i     (counter_we_i),
        .counter_wdata_i  (counter_wdata_i),
        .counter_rdata_o  (counter_rdata_o),
        .event_i          (event_i),
        .pending_o        (pending_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned m_cnt [N];
    logic [N-1:0] m_en, m_pend;
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_en   = '0;
        m_pend = '0;
    endfunction

    function automatic bit model_valid(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (off < 128) && (off[1:0] == 2'b00) && (off < 4 * N || off == 32'h40 || off == 32'h44);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] off);
        if (off < 4 * N) return m_cnt[off / 4];
        if (off == 32'h40) return 32'(m_en);
        return 32'(m_pend);
    endfunction

    // One clock edge of the bank as the register map and counting rules describe it.
    function automatic void model_edge(input bit wr, input logic [31:0] off, input logic [31:0] wdata,
                                       input logic [N-1:0] ev, input bit wfp_clr, input int wfp_idx);
        logic [N-1:0] set, clr;
        set = '0;
        clr = '0;
        for (int i = 0; i < N; i++) begin
            if (wr && off == 32'(4 * i)) m_cnt[i] = wdata;
            else if (m_en[i] && ev[i] && m_cnt[i] != 0) begin
                m_cnt[i] = m_cnt[i] - 1;
                if (m_cnt[i] == 0) set[i] = 1'b1;
            end
        end
        if (wr && off == 32'h44) clr = wdata[N-1:0];
        if (wr && off == 32'h40) m_en = wdata[N-1:0];
        if (wfp_clr) clr[wfp_idx] = 1'b1;
        m_pend = (m_pend & ~clr) | set;
    endfunction

    function automatic int lowest_pending();
        for (int i = 0; i < N; i++) if (m_pend[i]) return i;
        return -1;
    endfunction

    task automatic tick(input logic [N-1:0] ev);
        counter_op_i = PMC_IDLE;
        event_i      = ev;
        @(posedge clk_i);
        model_edge(0, 0, 0, ev, 0, 0);
        @(negedge clk_i);
        event_i = '0;
        chk("tick_pending", 32'(pending_o), 32'(m_pend));
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [N-1:0] ev, output logic [31:0] rd_obs);
        bit          ok;
        logic [31:0] off, exp_rd;
        ok     = model_valid(addr);
        off    = addr - BASE;
        exp_rd = ok ? model_read(off) : 32'd0;
        chk("req_gnt_idle", 32'(counter_gnt_o), 1);
        counter_op_i    = PMC_REQ;
        counter_addr_i  = addr;
        counter_we_i    = {$urandom()} & 32'hFFFF_FFFE | 32'(we);
        counter_wdata_i = wdata;
        event_i         = ev;
        @(posedge clk_i);
        model_edge(ok && we, off, wdata, ev, 0, 0);
        @(negedge clk_i);
        counter_op_i = PMC_IDLE;
        event_i      = '0;
        rd_obs       = counter_rdata_o;
        chk("req_rvalid", 32'(counter_rvalid_o), 1);
        chk("req_err", 32'(counter_err_o), 32'(!ok));
        chk("req_rdata", counter_rdata_o, exp_rd);
        chk("req_gnt_resp", 32'(counter_gnt_o), 0);
        chk("req_pending", 32'(pending_o), 32'(m_pend));
        @(posedge clk_i);
        model_edge(0, 0, 0, '0, 0, 0);
        @(negedge clk_i);
        chk("req_rvalid_drop", 32'(counter_rvalid_o), 0);
    endtask

    task automatic wr_reg(input logic [31:0] off, input logic [31:0] wdata);
        logic [31:0] rd;
        do_req(1'b1, BASE + off, wdata, '0, rd);
    endtask

    // WFP: ev_a/ev_b are driven in the first two WAIT cycles.
    task automatic do_wfp(input logic [N-1:0] ev_a, input logic [N-1:0] ev_b,
                          output logic [31:0] idx_obs, output int waited);
        bit          got;
        int          idx;
        logic [N-1:0] ev;
        got     = 0;
        waited  = 0;
        idx_obs = 32'hFFFF_FFFF;
        chk("wfp_gnt_idle", 32'(counter_gnt_o), 1);
        counter_op_i = PMC_WFP;
        event_i      = '0;
        @(posedge clk_i);
        model_edge(0, 0, 0, '0, 0, 0);
        @(negedge clk_i);
        while (!got && waited < 50) begin
            ev      = (waited == 0) ? ev_a : (waited == 1) ? ev_b : '0;
            event_i = ev;
            idx     = lowest_pending();
            @(posedge clk_i);
            model_edge(0, 0, 0, ev, idx >= 0, (idx >= 0) ? idx : 0);
            waited++;
            @(negedge clk_i);
            event_i = '0;
            if (idx >= 0) begin
                counter_op_i = PMC_IDLE;
                got          = 1;
                idx_obs      = counter_rdata_o;
                chk("wfp_rvalid", 32'(counter_rvalid_o), 1);
                chk("wfp_err", 32'(counter_err_o), 0);
                chk("wfp_rdata", counter_rdata_o, 32'(idx));
                chk("wfp_pending", 32'(pending_o), 32'(m_pend));
            end else begin
                chk("wfp_wait_gnt", 32'(counter_gnt_o), 0);
                chk("wfp_wait_rvalid", 32'(counter_rvalid_o), 0);
            end
        end
        counter_op_i = PMC_IDLE;
        chk("wfp_completed", 32'(got), 1);
        @(posedge clk_i);
        model_edge(0, 0, 0, '0, 0, 0);
        @(negedge clk_i);
        chk("wfp_back_idle", 32'(counter_gnt_o), 1);
    endtask

    initial begin
        logic [31:0] rd, addr, wdata;
        int          waited, sel;
        logic        we;

        rst_ni          = 1'b0;
        counter_op_i    = PMC_IDLE;
        counter_addr_i  = '0;
        counter_we_i    = '0;
        counter_wdata_i = '0;
        event_i         = '0;
        model_reset();
        repeat (3) @(negedge clk_i);
        chk("rst_gnt", 32'(counter_gnt_o), 1);
        chk("rst_rvalid", 32'(counter_rvalid_o), 0);
        chk("rst_err", 32'(counter_err_o), 0);
        chk("rst_rdata", counter_rdata_o, 0);
        chk("rst_pending", 32'(pending_o), 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        do_req(1'b1, BASE + 32'h0C, 32'd5, '0, rd);
        do_req(1'b0, BASE + 32'h0C, 32'd0, '0, rd);
        chk("cnt3_readback", rd, 32'd5);

        wr_reg(32'h40, 32'h08);
        wr_reg(32'h0C, 32'd2);
        tick(8'h08);
        tick(8'h08);
        chk("cnt3_pending_after_2", 32'(pending_o), 32'h08);
        tick(8'h08);
        do_req(1'b0, BASE + 32'h0C, 0, '0, rd);
        chk("cnt3_holds_zero", rd, 32'd0);
        do_req(1'b0, BASE + 32'h44, 0, '0, rd);
        chk("pending_reg", rd, 32'h08);

        wr_reg(32'h44, 32'hFF);
        wr_reg(32'h40, 32'h22);
        wr_reg(32'h04, 32'd1);
        wr_reg(32'h14, 32'd1);
        do_wfp(8'h20, 8'h02, rd, waited);
        chk("wfp1_index", rd, 32'd5);
        do_wfp('0, '0, rd, waited);
        chk("wfp2_index", rd, 32'd1);
        chk("wfp2_latency", 32'(waited), 1);

        do_req(1'b1, BASE + 32'h48, 32'hFFFF_FFFF, '0, rd);
        do_req(1'b1, BASE + 32'h02, 32'hFFFF_FFFF, '0, rd);
        do_req(1'b1, BASE + 32'h80, 32'hFFFF_FFFF, '0, rd);
        do_req(1'b0, BASE + 32'h04, 0, '0, rd);
        chk("err_left_cnt1", rd, 32'd0);

        wr_reg(32'h40, 32'h01);
        wr_reg(32'h00, 32'd3);
        do_req(1'b1, BASE + 32'h00, 32'd7, 8'h01, rd);
        do_req(1'b0, BASE + 32'h00, 0, '0, rd);
        chk("collide_cnt0", rd, 32'd7);
        chk("collide_no_pend0", 32'(pending_o[0]), 0);

        wr_reg(32'h40, 32'h04);
        wr_reg(32'h08, 32'd1);
        tick(8'h04);
        wr_reg(32'h08, 32'd1);
        do_req(1'b1, BASE + 32'h44, 32'h04, 8'h04, rd);
        chk("w1c_set_wins", 32'(pending_o[2]), 1);

        wr_reg(32'h40, {$urandom()});
        for (int it = 0; it < 150; it++) begin
            repeat ($urandom_range(0, 2)) tick(N'($urandom()));
            sel = $urandom_range(0, 11);
            if (sel < 8) addr = BASE + 32'(4 * sel);
            else if (sel == 8) addr = BASE + 32'h40;
            else if (sel == 9) addr = BASE + 32'h44;
            else if (sel == 10) addr = BASE + 32'h48 + 32'(4 * $urandom_range(0, 13));
            else if ($urandom_range(0, 1) == 1) addr = BASE + 32'(4 * $urandom_range(0, 17)) + 32'($urandom_range(1, 3));
            else addr = ($urandom_range(0, 1) == 1) ? BASE + 32'h80 + 32'(4 * $urandom_range(0, 17)) : BASE - 32'h80;
            wdata = (sel < 8) ? 32'($urandom_range(0, 4)) : $urandom();
            we    = 1'($urandom_range(0, 1));
            do_req(we, addr, wdata, N'($urandom()), rd);
        end

        wr_reg(32'h40, 32'h00);
        wr_reg(32'h44, 32'hFF);
        counter_op_i = PMC_WFP;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("abort_wait_gnt", 32'(counter_gnt_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        counter_op_i = PMC_IDLE;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("abort_gnt", 32'(counter_gnt_o), 1);
        chk("abort_no_rvalid", 32'(counter_rvalid_o), 0);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("abort_no_rvalid_late", 32'(counter_rvalid_o), 0);

        wr_reg(32'h10, 32'd9);
        wr_reg(32'h40, 32'h10);
        counter_op_i = PMC_WFP;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rstwait_in_wait", 32'(counter_gnt_o), 0);
        rst_ni = 1'b0;
        #1;
        chk("rstwait_gnt", 32'(counter_gnt_o), 1);
        chk("rstwait_rvalid", 32'(counter_rvalid_o), 0);
        chk("rstwait_rdata", counter_rdata_o, 0);
        model_reset();
        counter_op_i = PMC_IDLE;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rstwait_no_rvalid", 32'(counter_rvalid_o), 0);
        for (int i = 0; i < N; i++) do_req(1'b0, BASE + 32'(4 * i), 0, '0, rd);
        do_req(1'b0, BASE + 32'h40, 0, '0, rd);
        chk("rstwait_enable_zero", rd, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ibex_pmu_counter_bank.md
Name: ibex_pmu_counter_bank

Overview:
- PMU-side target of the core's counter interface; sits directly downstream of the core's PMC request unit.
- Holds NumCounters 32-bit down-counters driven by hardware event strobes.
- Serves single-beat register read/write requests (PMC_REQ).
- Serves wait-for-pulse requests (PMC_WFP) that block until a counter expires, then return the expired counter's index.

Parameters:
- NumCounters, 8, number of event counters (1..16).
- BaseAddr, 32'h0000_0000, byte base of the 128-byte register window; bits [6:0] are zero.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- counter_op_i  in  ibex_pkg::pmc_op_e  PMC_IDLE / PMC_REQ / PMC_WFP from the core
- counter_gnt_o  out  1  bank ready to accept an op
- counter_rvalid_o  out  1  response valid, one-cycle pulse
- counter_err_o  out  1  qualifies rvalid; request failed
- counter_addr_i  in  32  byte address
- counter_we_i  in  32  write enable; only bit 0 used, bits [31:1] ignored
- counter_wdata_i  in  32  write data
- counter_rdata_o  out  32  read data, or WFP index
- event_i  in  NumCounters  per-counter event strobe, one decrement per high cycle
- pending_o  out  NumCounters  current pending flags (for PMU-side interrupt logic)

Behaviour:
- Reset:
  - All counters, ENABLE and PENDING are 0; FSM is IDLE.
  - counter_gnt_o=1, counter_rvalid_o=0, counter_err_o=0, counter_rdata_o=0.
- Register map, offset = addr - BaseAddr, valid only when addr[31:7]==BaseAddr[31:7] and addr[1:0]==0:
  - 0x00+4*i: CNT[i] (R/W), for i<NumCounters.
  - 0x40: ENABLE (R/W), bits >=NumCounters read 0 and ignore writes.
  - 0x44: PENDING (R, write-1-to-clear).
  - Any other offset, or a misaligned address: error.
- Counting: each cycle, for each i with ENABLE[i] && event_i[i] && CNT[i]!=0:
  - CNT[i] decrements by 1.
  - If the result is 0, PENDING[i] sets.
  - CNT[i]==0 never wraps; it holds at 0.
- FSM states: IDLE, RESP, WAIT.
- IDLE:
  - gnt=1. Accept occurs in the cycle op!=PMC_IDLE while gnt=1.
  - PMC_REQ: decode addr/we/wdata in the accept cycle T.
    - Writes commit at the edge ending T.
    - Read data is the pre-write value at T, registered.
    - Go to RESP.
  - PMC_WFP: go to WAIT.
- RESP:
  - gnt=0; rvalid=1 with registered rdata/err for exactly this cycle (T+1).
  - Then IDLE; counter_op_i is ignored in this state.
- WAIT:
  - gnt=0; op is held at PMC_WFP by the core.
  - If PENDING!=0, register rdata = index of the lowest set bit (zero-extended) and clear that bit. Go to RESP, so rvalid comes one cycle after pending is seen.
  - If op drops to PMC_IDLE with nothing pending, abort to IDLE with no response.
- Errors:
  - rvalid=1, err=1, rdata=0; no state is modified.
  - Errors apply to REQ only; WFP never errors.
- Non-error responses: err=0.
- rdata is held stable outside rvalid (last value); no checker relies on it.
- Simultaneous events:
  - Register write to CNT[i] in the same cycle as a decrement of i: the write wins and no pending is set that cycle.
  - W1C of PENDING[i] in the same cycle as a set of PENDING[i]: the set wins.
  - WFP clear of bit i in the same cycle as a new set of bit i: the set wins, bit stays 1.
  - Write of 0 to CNT[i] does not set PENDING[i].
- Asynchronous reset asserted mid-transaction (RESP/WAIT):
  - FSM returns to IDLE immediately with all outputs at reset values.
  - No response is issued for the in-flight request.
- No back-to-back accepts: minimum spacing between accepts is 2 cycles (accept, RESP).

Test Plan:
- Write/read CNT[3]:
  - REQ we=1 addr=BaseAddr+0x0C wdata=5 -> rvalid at T+1, err=0.
  - REQ read of the same address -> rvalid at T+1, rdata=5.
- Countdown and pending:
  - ENABLE=0x08, CNT[3]=2, pulse event_i[3] three cycles -> CNT[3]=0 and stays 0.
  - PENDING reads 0x08; pending_o[3]=1 from the cycle after the second pulse.
- WFP:
  - CNT[1]=1, CNT[5]=1, ENABLE=0x22, hold op=PMC_WFP, pulse event_i[5] then event_i[1] -> first WFP returns rdata=5 and clears PENDING[5].
  - Second WFP returns rdata=1 immediately, one cycle after entering WAIT.
- Errors:
  - REQ to addr=BaseAddr+0x48, to addr=BaseAddr+0x02, and to an address outside the window -> each gives rvalid=1, err=1, rdata=0; registers unchanged.
- Collisions:
  - Same-cycle CNT[0] write of 7 and decrementing event -> CNT[0]=7, no pending.
  - Same-cycle W1C PENDING[2] and expiry of counter 2 -> PENDING[2]=1.
- Reset and abort:
  - Assert rst_ni low during WAIT -> next edge gnt=1, rvalid=0, all registers 0.
  - Drop op to PMC_IDLE in WAIT with PENDING=0 -> returns to IDLE, no rvalid.
